mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//   Shares one sequential signed multiplier (start/src1/src2 -> done/product) between
//   NUM_REQ requesters. Round-robin arbitration; the block issues one operation at a
//   time, waits for completion and returns the result tagged with the requester id.
//   Sits between ALU clients and the multiplier, which it drives through its mul_* ports.
// PARAMETERS
//   NUM_REQ   4    number of requesters (2..8)
//   WIDTH     8    operand/result width; matches the multiplier product width
//   TIMEOUT   64   max WAIT cycles before abort (must exceed multiplier latency of 2*WIDTH+2)
// PORTS
//   clk          in   1               clock, rising edge
//   rst          in   1               synchronous active-high reset
//   req          in   NUM_REQ         request per client; held with operands until req_ack
//   a_flat       in   NUM_REQ*WIDTH   operand A per client, slice i = [i*WIDTH +: WIDTH]
//   b_flat       in   NUM_REQ*WIDTH   operand B per client, same slicing
//   req_ack      out  NUM_REQ         one-hot 1-cycle pulse: client operands captured
//   rsp_valid    out  1               1-cycle pulse: rsp_data/rsp_id valid
//   rsp_id       out  $clog2(NUM_REQ) requester index of the returned result
//   rsp_data     out  WIDTH           low WIDTH bits of signed product
//   err_timeout  out  1               1-cycle pulse: operation aborted on timeout
//   busy         out  1               high in every state except IDLE
//   mul_start    out  1               1-cycle start pulse to multiplier
//   mul_src1     out  WIDTH           latched operand A
//   mul_src2     out  WIDTH           latched operand B
//   mul_product  in   WIDTH           multiplier result
//   mul_done     in   1               multiplier completion pulse
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, rr pointer=0, every output 0, timer=0.
//   - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; WAIT -> IDLE on timeout.
//   - IDLE: if |req, pick first set bit scanning from rr_ptr upward with wrap; latch
//     a/b slices into mul_src1/2, latch id, pulse req_ack[id], rr_ptr <= id+1 (wraps
//     to 0 after NUM_REQ-1), go ISSUE. No req: stay, all pulses 0.
//   - ISSUE: mul_start=1 for exactly this cycle; timer cleared; go WAIT.
//   - WAIT: timer increments each cycle. mul_done=1 -> rsp_data<=mul_product,
//     go RESP (mul_done wins if coincident with timer==TIMEOUT-1). timer reaches
//     TIMEOUT-1 without done -> pulse err_timeout, go IDLE, no rsp_valid.
//   - RESP: rsp_valid=1 one cycle with rsp_id/rsp_data; rsp_data/rsp_id hold until next RESP.
//   - Issue latency: req seen in IDLE cycle t -> req_ack at t+1 edge, mul_start the
//     following cycle; rsp_valid one cycle after mul_done.
//   - mul_done outside WAIT ignored (stale completion after reset/timeout).
//   - req deasserted by client after ack is legal; req changes in ISSUE/WAIT/RESP
//     are ignored until next IDLE. Back-to-back: at least one IDLE cycle between ops.
//   - Reset mid-operation: in-flight op discarded, no rsp_valid/err pulse generated.
//   - Operands/product are two's complement; width truncation done by multiplier.
// STRUCTURE
//   - Shared package/header: FSM state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits),
//     ID_W = $clog2(NUM_REQ) helper.
//   - One sub-module: rr_pick (comb; req + rr_ptr -> grant valid + index).
//   - Multiplier not instantiated here; top level wires mul_* ports to it.
// TESTING (bench instantiates the 8-bit sequential multiplier behind mul_*)
//   1. req=4'b0001, a0=3, b0=5 -> req_ack=0001, one mul_start, rsp_valid, id=0, data=15.
//   2. req=4'b1111 held, reloaded after each ack -> rsp_id order 0,1,2,3,0.
//   3. a2=8'hFD(-3), b2=4 only -> rsp_id=2, rsp_data=8'hF4(-12); a1=-2,b1=-7 -> 14.
//   4. After grant to 2, req=4'b0101 -> next grant 0 (wrap), then 2.
//   5. Stub multiplier never asserts done -> err_timeout pulse TIMEOUT cycles after
//      mul_start, no rsp_valid, busy=0; next request served normally.
//   6. rst in WAIT, then stub pulses mul_done -> no rsp_valid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and id-width helper.
package mul_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   // Requester index width; never below one bit so ports stay legal.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping to index 0.
module mul_arbiter_rr_pick
   import mul_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IdW     = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdW-1:0]     ptr_i,
   output logic               valid_o,
   output logic [IdW-1:0]     idx_o
);

   logic [IdW-1:0] cidx;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cidx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cidx = IdW'((32'(ptr_i) + k) % NUM_REQ);
         if (!valid_o && req_i[cidx]) begin
            valid_o = 1'b1;
            idx_o   = cidx;
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between NUM_REQ clients, round-robin, one op at a time.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] a_flat,
   input  logic [NUM_REQ*WIDTH-1:0] b_flat,
   output logic [NUM_REQ-1:0]       req_ack,
   output logic                     rsp_valid,
   output logic [id_w(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     err_timeout,
   output logic                     busy,
   output logic                     mul_start,
   output logic [WIDTH-1:0]         mul_src1,
   output logic [WIDTH-1:0]         mul_src2,
   input  logic [WIDTH-1:0]         mul_product,
   input  logic                     mul_done
);

   localparam int unsigned IdW  = id_w(NUM_REQ);
   localparam int unsigned TmrW = $clog2(TIMEOUT);

   state_e               state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       id_q, id_d;
   logic [TmrW-1:0]      timer_q, timer_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IdW-1:0]       rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 mul_start_q, mul_start_d;
   logic [WIDTH-1:0]     src1_q, src1_d;
   logic [WIDTH-1:0]     src2_q, src2_d;

   logic                 pick_valid;
   logic [IdW-1:0]       pick_idx;
   logic [WIDTH-1:0]     a_arr [NUM_REQ];
   logic [WIDTH-1:0]     b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign a_arr[i] = a_flat[i*WIDTH +: WIDTH];
      assign b_arr[i] = b_flat[i*WIDTH +: WIDTH];
   end

   mul_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IdW     (IdW)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      timer_d     = timer_q;
      req_ack_d   = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      err_d       = 1'b0;
      mul_start_d = 1'b0;
      src1_d      = src1_q;
      src2_d      = src2_q;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               src1_d              = a_arr[pick_idx];
               src2_d              = b_arr[pick_idx];
               id_d                = pick_idx;
               req_ack_d[pick_idx] = 1'b1;
               rr_ptr_d            = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IdW'(1);
               state_d             = StIssue;
            end
         end
         StIssue: begin
            mul_start_d = 1'b1;
            timer_d     = '0;
            state_d     = StWait;
         end
         StWait: begin
            // Completion takes priority over a coincident timeout.
            if (mul_done) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = mul_product;
               state_d     = StResp;
            end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         timer_q     <= '0;
         req_ack_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         src1_q      <= '0;
         src2_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         timer_q     <= timer_d;
         req_ack_q   <= req_ack_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
      end
   end

   assign req_ack     = req_ack_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign err_timeout = err_q;
   assign busy        = busy_q;
   assign mul_start   = mul_start_q;
   assign mul_src1    = src1_q;
   assign mul_src2    = src2_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural 8-bit multiplier behind mul_*, transaction-timeline
// reference model checked every cycle, plus directed literal expectations.
module tb_mul_arbiter;

   localparam int NR  = 4;
   localparam int W   = 8;
   localparam int TO  = 64;
   localparam int LAT = 2 * W + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] a_flat = '0;
   logic [31:0] b_flat = '0;
   logic [3:0]  req_ack;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        err_timeout;
   logic        busy;
   logic        mul_start;
   logic [7:0]  mul_src1;
   logic [7:0]  mul_src2;
   logic [7:0]  mul_product;
   logic        mul_done;

   logic        stub = 1'b0;
   logic        force_done = 1'b0;
   logic        mdone_q = 1'b0;
   logic [7:0]  mprod = '0;
   int          mcnt = 0;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic        cmp_en = 1'b0;

   always #5 clk = ~clk;

   mul_arbiter #(
      .NUM_REQ (NR),
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .a_flat      (a_flat),
      .b_flat      (b_flat),
      .req_ack     (req_ack),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .err_timeout (err_timeout),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_src1    (mul_src1),
      .mul_src2    (mul_src2),
      .mul_product (mul_product),
      .mul_done    (mul_done)
   );

   // Sequential multiplier: done pulses LAT cycles after start; stub mode never finishes.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mdone_q <= 1'b0;
      if (mul_start && !stub) begin
         mcnt  <= LAT;
         mprod <= mul_src1 * mul_src2;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) mdone_q <= 1'b1;
      end
   end
   assign mul_done    = mdone_q | force_done;
   assign mul_product = mprod;

   // Reference model: tracks one transaction as "edges since grant" rather than FSM states.
   typedef struct packed {
      logic        active;
      logic        resp;
      int unsigned since;
      logic [1:0]  ptr;
      logic [1:0]  id;
      logic [3:0]  ack;
      logic        valid;
      logic [1:0]  rid;
      logic [7:0]  data;
      logic        err;
      logic        busy;
      logic        start;
      logic [7:0]  src1;
      logic [7:0]  src2;
   } mdl_t;

   mdl_t mdl = '0;

   function automatic mdl_t step(input mdl_t m, input logic r, input logic [3:0] rq,
                                 input logic [31:0] af, input logic [31:0] bf,
                                 input logic dn, input logic [7:0] pr);
      mdl_t        n;
      int unsigned k;
      int          c;
      n       = m;
      n.ack   = '0;
      n.valid = 1'b0;
      n.err   = 1'b0;
      n.start = 1'b0;
      if (r) begin
         n = '0;
      end else if (!m.active) begin
         n.busy = 1'b0;
         for (int j = 0; j < NR; j++) begin
            c = (int'(m.ptr) + j) % NR;
            if (!n.active && rq[c]) begin
               n.active = 1'b1;
               n.resp   = 1'b0;
               n.since  = 0;
               n.id     = 2'(c);
               n.ack[c] = 1'b1;
               n.src1   = af[c*W +: W];
               n.src2   = bf[c*W +: W];
               n.ptr    = 2'((c + 1) % NR);
               n.busy   = 1'b1;
            end
         end
      end else if (m.resp) begin
         n.active = 1'b0;
         n.resp   = 1'b0;
         n.busy   = 1'b0;
      end else begin
         k       = m.since + 1;
         n.since = k;
         if (k == 1) begin
            n.start = 1'b1;
         end else if (dn) begin
            n.valid = 1'b1;
            n.rid   = m.id;
            n.data  = pr;
            n.resp  = 1'b1;
         end else if (k - 1 == TO) begin
            n.err    = 1'b1;
            n.active = 1'b0;
            n.busy   = 1'b0;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      mdl <= step(mdl, rst, req, a_flat, b_flat, mul_done, mul_product);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("req_ack",     32'(req_ack),     32'(mdl.ack));
         check("rsp_valid",   32'(rsp_valid),   32'(mdl.valid));
         check("rsp_id",      32'(rsp_id),      32'(mdl.rid));
         check("rsp_data",    32'(rsp_data),    32'(mdl.data));
         check("err_timeout", 32'(err_timeout), 32'(mdl.err));
         check("busy",        32'(busy),        32'(mdl.busy));
         check("mul_start",   32'(mul_start),   32'(mdl.start));
         check("mul_src1",    32'(mul_src1),    32'(mdl.src1));
         check("mul_src2",    32'(mul_src2),    32'(mdl.src2));
      end
   end

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      a_flat[i*W +: W] = a;
      b_flat[i*W +: W] = b;
   endtask

   task automatic wait_ack(input logic [3:0] want, input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if (req_ack != 4'b0) begin
            got = 1'b1;
            check(name, 32'(req_ack), 32'(want));
         end
      end
      check({name, "_seen"}, 32'(got), 32'd1);
   endtask

   task automatic wait_rsp(input logic [1:0] want_id, input logic [7:0] want_data,
                           input string name, output int starts);
      logic got;
      got    = 1'b0;
      starts = 0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if (mul_start) starts++;
         if (rsp_valid) begin
            got = 1'b1;
            check({name, "_id"},   32'(rsp_id),   32'(want_id));
            check({name, "_data"}, 32'(rsp_data), 32'(want_data));
         end
      end
      check({name, "_seen"}, 32'(got), 32'd1);
   endtask

   task automatic wait_start(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (mul_start) got = 1'b1;
      end
      check(name, 32'(got), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1);
   end

   initial begin
      int          starts;
      int          t0;
      int          t1;
      logic        got;
      logic        saw;
      logic [1:0]  exp_ids [5];
      exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      t0 = 0;
      t1 = 0;

      // Reset state
      @(negedge clk);
      check("rst_req_ack",   32'(req_ack),     32'd0);
      check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
      check("rst_busy",      32'(busy),        32'd0);
      check("rst_mul_start", 32'(mul_start),   32'd0);
      check("rst_err",       32'(err_timeout), 32'd0);
      cmp_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: single client, 3*5
      set_op(0, 8'd3, 8'd5);
      req = 4'b0001;
      wait_ack(4'b0001, "t1_ack");
      req = 4'b0000;
      wait_rsp(2'd0, 8'd15, "t1_rsp", starts);
      check("t1_one_start", 32'(starts), 32'd1);

      // 2: all clients held, round-robin from a fresh pointer
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NR; i++) set_op(i, 8'(i + 2), 8'd3);
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_rsp(exp_ids[n], 8'((int'(exp_ids[n]) + 2) * 3), $sformatf("t2_rsp%0d", n), starts);
      end
      req = 4'b0000;
      @(negedge clk);

      // 3: signed operands
      set_op(2, 8'hFD, 8'h04);
      req = 4'b0100;
      wait_ack(4'b0100, "t3_ack2");
      req = 4'b0000;
      wait_rsp(2'd2, 8'hF4, "t3_rsp2", starts);
      set_op(1, 8'hFE, 8'hF9);
      req = 4'b0010;
      wait_ack(4'b0010, "t3_ack1");
      req = 4'b0000;
      wait_rsp(2'd1, 8'd14, "t3_rsp1", starts);

      // 4: pointer wraps past the top client
      set_op(0, 8'd2, 8'd2);
      set_op(2, 8'd5, 8'd5);
      req = 4'b0100;
      wait_ack(4'b0100, "t4_ack_a");
      req = 4'b0101;
      wait_ack(4'b0001, "t4_ack_b");
      wait_ack(4'b0100, "t4_ack_c");
      req = 4'b0000;
      wait_rsp(2'd2, 8'd25, "t4_rsp", starts);

      // 5: multiplier never completes
      stub = 1'b1;
      set_op(0, 8'd9, 8'd9);
      req = 4'b0001;
      wait_ack(4'b0001, "t5_ack");
      req = 4'b0000;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (mul_start) begin
            got = 1'b1;
            t0  = cyc;
         end
      end
      check("t5_start_seen", 32'(got), 32'd1);
      got = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
         if (err_timeout) begin
            got = 1'b1;
            t1  = cyc;
            check("t5_busy_at_err", 32'(busy), 32'd0);
         end
      end
      check("t5_err_seen",  32'(got),     32'd1);
      check("t5_err_delay", 32'(t1 - t0), 32'(TO));
      check("t5_no_rsp",    32'(saw),     32'd0);
      stub = 1'b0;
      set_op(1, 8'd7, 8'd6);
      req = 4'b0010;
      wait_ack(4'b0010, "t5_ack_next");
      req = 4'b0000;
      wait_rsp(2'd1, 8'd42, "t5_rsp_next", starts);

      // 6: reset during WAIT, then a stale completion
      stub = 1'b1;
      set_op(0, 8'd3, 8'd3);
      req = 4'b0001;
      wait_ack(4'b0001, "t6_ack");
      req = 4'b0000;
      wait_start("t6_start_seen");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      force_done = 1'b1;
      check("t6_rsp_valid", 32'(rsp_valid),   32'd0);
      check("t6_busy",      32'(busy),        32'd0);
      check("t6_src1",      32'(mul_src1),    32'd0);
      check("t6_rsp_data",  32'(rsp_data),    32'd0);
      check("t6_rsp_id",    32'(rsp_id),      32'd0);
      check("t6_err",       32'(err_timeout), 32'd0);
      @(negedge clk);
      force_done = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid || busy || err_timeout || mul_start) saw = 1'b1;
      end
      check("t6_quiet", 32'(saw), 32'd0);
      stub = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
